receptor_serial: RTL and testbench

Serial-to-parallel front end for the character decoder FSM. Assembles one start bit, 7 data bits (MSB first) and one stop bit from a single-wire line into a 7-bit character code. Presents each valid code with a one-cycle Controle strobe to the downstream decoder's Entrada/Controle inputs and flags framing errors. Sampling is paced by an external bit-rate strobe (Habilita), so the block has no internal baud divider.

---
 rtl/receptor_serial_pkg.sv | 28 ++
 rtl/receptor_serial_registrador_deslocamento.sv | 28 ++
 rtl/receptor_serial.sv | 160 ++++++++++++++++
 tb/tb_receptor_serial.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/receptor_serial_pkg.sv
// Shared definitions for the serial character receiver and the downstream
// character decoder: state encoding, default character width, and the
// character codes both blocks agree on.
package receptor_serial_pkg;

  // Default number of data bits per character
  localparam int unsigned LARGURA_PADRAO = 7;

  // Receiver frame states; PARIDADE is only reached when parity is built in
  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    DADOS        = 3'd1,
    PARIDADE     = 3'd2,
    PARADA       = 3'd3,
    ESPERA_LINHA = 3'd4
  } estado_t;

  // Character codes recognised by the decoder
  localparam logic [LARGURA_PADRAO-1:0] C1 = 7'h31;
  localparam logic [LARGURA_PADRAO-1:0] C2 = 7'h32;
  localparam logic [LARGURA_PADRAO-1:0] C3 = 7'h33;
  localparam logic [LARGURA_PADRAO-1:0] C4 = 7'h34;
  localparam logic [LARGURA_PADRAO-1:0] C5 = 7'h35;
  localparam logic [LARGURA_PADRAO-1:0] C6 = 7'h36;
  localparam logic [LARGURA_PADRAO-1:0] C7 = 7'h37;
  localparam logic [LARGURA_PADRAO-1:0] C8 = 7'h38;

endpackage

// File: rtl/receptor_serial_registrador_deslocamento.sv
// LARGURA-bit shift-in register: new bits enter at the LSB, so the first bit
// shifted in ends up in the MSB after LARGURA shifts.
module receptor_serial_registrador_deslocamento
  import receptor_serial_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               i_limpa,
  input  logic               i_habilita,
  input  logic               i_bit,
  output logic [LARGURA-1:0] o_dados
);

  logic [LARGURA-1:0] r_dados;

  // Synchronous clear has priority over shifting
  always_ff @(posedge clk) begin
    if (i_limpa) begin
      r_dados <= '0;
    end else if (i_habilita) begin
      r_dados <= {r_dados[LARGURA-2:0], i_bit};
    end
  end

  assign o_dados = r_dados;

endmodule

// File: rtl/receptor_serial.sv
// Serial-to-parallel receiver: start bit, LARGURA data bits MSB first, stop
// bit, all sampled on the external Habilita bit strobe. Produces a one-cycle
// Controle strobe with each good character and a one-cycle Erro on framing
// faults. Define RECEPTOR_PARIDADE_EN to add an even-parity bit before stop.
module receptor_serial
  import receptor_serial_pkg::*;
#(
  parameter int unsigned LARGURA      = LARGURA_PADRAO,
  parameter logic        OCIOSO_NIVEL = 1'b1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Dado_serial,
  input  logic               Habilita,
  output logic [LARGURA-1:0] Caractere,
  output logic               Controle,
  output logic               Erro,
  output logic               Ocupado
);

  localparam int unsigned LARGURA_CONT = $clog2(LARGURA + 1);

  estado_t                 r_estado, w_estado_prox;
  logic [LARGURA_CONT-1:0] r_cont, w_cont_prox;
  logic [LARGURA-1:0]      r_caractere, w_caractere_prox;
  logic                    r_controle, w_controle_prox;
  logic                    r_erro, w_erro_prox;
  logic                    r_ocupado, w_ocupado_prox;
  logic                    w_desloca;
  logic [LARGURA-1:0]      w_registro;
`ifdef RECEPTOR_PARIDADE_EN
  logic                    r_par_erro, w_par_erro_prox;
`endif

  // Data bits accumulate here while in DADOS
  receptor_serial_registrador_deslocamento #(
    .LARGURA (LARGURA)
  ) u_registrador_deslocamento (
    .clk        (clk),
    .i_limpa    (Reset),
    .i_habilita (w_desloca),
    .i_bit      (Dado_serial),
    .o_dados    (w_registro)
  );

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_estado    <= OCIOSO;
      r_cont      <= '0;
      r_caractere <= '0;
      r_controle  <= 1'b0;
      r_erro      <= 1'b0;
      r_ocupado   <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
      r_par_erro  <= 1'b0;
`endif
    end else begin
      r_estado    <= w_estado_prox;
      r_cont      <= w_cont_prox;
      r_caractere <= w_caractere_prox;
      r_controle  <= w_controle_prox;
      r_erro      <= w_erro_prox;
      r_ocupado   <= w_ocupado_prox;
`ifdef RECEPTOR_PARIDADE_EN
      r_par_erro  <= w_par_erro_prox;
`endif
    end
  end

  // Next-state and next-output logic; everything advances only on Habilita
  always_comb begin
    w_estado_prox    = r_estado;
    w_cont_prox      = r_cont;
    w_caractere_prox = r_caractere;
    w_controle_prox  = 1'b0;
    w_erro_prox      = 1'b0;
    w_ocupado_prox   = r_ocupado;
    w_desloca        = 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
    w_par_erro_prox  = r_par_erro;
`endif

    if (Habilita) begin
      case (r_estado)
        OCIOSO: begin
          if (Dado_serial == ~OCIOSO_NIVEL) begin
            w_estado_prox  = DADOS;
            w_cont_prox    = '0;
            w_ocupado_prox = 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
            w_par_erro_prox = 1'b0;
`endif
          end
        end

        DADOS: begin
          w_desloca   = 1'b1;
          w_cont_prox = r_cont + LARGURA_CONT'(1);
          if (r_cont == LARGURA_CONT'(LARGURA - 1)) begin
`ifdef RECEPTOR_PARIDADE_EN
            w_estado_prox = PARIDADE;
`else
            w_estado_prox = PARADA;
`endif
          end
        end

`ifdef RECEPTOR_PARIDADE_EN
        // Even parity: the parity bit must equal the XOR of the data bits
        PARIDADE: begin
          if (Dado_serial != (^w_registro)) begin
            w_par_erro_prox = 1'b1;
          end
          w_estado_prox = PARADA;
        end
`endif

        PARADA: begin
          w_ocupado_prox = 1'b0;
          if (Dado_serial == OCIOSO_NIVEL) begin
            w_estado_prox = OCIOSO;
`ifdef RECEPTOR_PARIDADE_EN
            if (r_par_erro) begin
              w_erro_prox = 1'b1;
            end else begin
              w_caractere_prox = w_registro;
              w_controle_prox  = 1'b1;
            end
`else
            w_caractere_prox = w_registro;
            w_controle_prox  = 1'b1;
`endif
          end else begin
            w_erro_prox   = 1'b1;
            w_estado_prox = ESPERA_LINHA;
          end
        end

        // A held-low line (break) must return idle before a new start counts
        ESPERA_LINHA: begin
          if (Dado_serial == OCIOSO_NIVEL) begin
            w_estado_prox = OCIOSO;
          end
        end

        default: begin
          w_estado_prox  = OCIOSO;
          w_ocupado_prox = 1'b0;
        end
      endcase
    end
  end

  assign Caractere = r_caractere;
  assign Controle  = r_controle;
  assign Erro      = r_erro;
  assign Ocupado   = r_ocupado;

endmodule

// File: tb/tb_receptor_serial.sv
// Self-checking bench for receptor_serial: directed frames plus randomized
// frames, gaps, line noise, bad stop bits and mid-frame resets, compared
// every cycle against a frame-level reference model.
module tb_receptor_serial;

  localparam int unsigned LARG = 7;
`ifdef RECEPTOR_PARIDADE_EN
  localparam int N_CORPO = LARG + 2;
`else
  localparam int N_CORPO = LARG + 1;
`endif

  logic            clk = 1'b0;
  logic            Reset;
  logic            Dado_serial;
  logic            Habilita;
  logic [LARG-1:0] Caractere;
  logic            Controle;
  logic            Erro;
  logic            Ocupado;

  always #5 clk = ~clk;

  receptor_serial #(
    .LARGURA      (LARG),
    .OCIOSO_NIVEL (1'b1)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Dado_serial (Dado_serial),
    .Habilita    (Habilita),
    .Caractere   (Caractere),
    .Controle    (Controle),
    .Erro        (Erro),
    .Ocupado     (Ocupado)
  );

  int n_checks = 0;
  int n_erros  = 0;

  // Reference model state
  logic [LARG-1:0] m_car;
  logic            m_controle, m_erro, m_ocupado;
  bit              m_em_quadro, m_esperando;
  bit              m_bits[$];

  // Stimulus knobs
  int intervalo = 4;
  bit ruido     = 1'b0;

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic checar_saidas(input string tag);
    checar({tag, "_caractere"}, 32'(Caractere), 32'(m_car));
    checar({tag, "_controle"},  32'(Controle),  32'(m_controle));
    checar({tag, "_erro"},      32'(Erro),      32'(m_erro));
    checar({tag, "_ocupado"},   32'(Ocupado),   32'(m_ocupado));
  endtask

  task automatic modelo_reset();
    m_car       = '0;
    m_controle  = 1'b0;
    m_erro      = 1'b0;
    m_ocupado   = 1'b0;
    m_em_quadro = 1'b0;
    m_esperando = 1'b0;
    m_bits.delete();
  endtask

  // Frame-level model: collect the samples after a start bit, then judge the
  // whole frame at once once it is complete.
  task automatic modelo_amostra(input logic b);
    logic [LARG-1:0] dado;
    bit              par_ok;
    m_controle = 1'b0;
    m_erro     = 1'b0;
    if (m_esperando) begin
      if (b) m_esperando = 1'b0;
    end else if (!m_em_quadro) begin
      if (!b) begin
        m_em_quadro = 1'b1;
        m_ocupado   = 1'b1;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == N_CORPO) begin
        dado = '0;
        for (int i = 0; i < int'(LARG); i++) dado[LARG-1-i] = m_bits[i];
        par_ok = 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
        par_ok = (m_bits[LARG] == (^dado));
`endif
        m_em_quadro = 1'b0;
        m_ocupado   = 1'b0;
        if (m_bits[N_CORPO-1] && par_ok) begin
          m_car      = dado;
          m_controle = 1'b1;
        end else begin
          m_erro      = 1'b1;
          m_esperando = !m_bits[N_CORPO-1];
        end
      end
    end
  endtask

  // One bit period: a Habilita cycle followed by intervalo-1 quiet cycles
  task automatic amostra(input logic b);
    Dado_serial = b;
    Habilita    = 1'b1;
    @(posedge clk);
    #1;
    Habilita = 1'b0;
    modelo_amostra(b);
    checar_saidas("hab");
    m_controle = 1'b0;
    m_erro     = 1'b0;
    for (int i = 1; i < intervalo; i++) begin
      if (ruido) Dado_serial = ~Dado_serial;
      @(posedge clk);
      #1;
      checar_saidas("quieto");
    end
  endtask

  task automatic aplicar_reset();
    Reset       = 1'b1;
    Habilita    = 1'($urandom_range(0, 1));
    Dado_serial = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    Reset    = 1'b0;
    Habilita = 1'b0;
    modelo_reset();
    checar_saidas("reset");
  endtask

  task automatic enviar_quadro(input logic [LARG-1:0] dado, input logic parada, input logic par_inv);
    amostra(1'b0);
    for (int i = int'(LARG) - 1; i >= 0; i--) amostra(dado[i]);
`ifdef RECEPTOR_PARIDADE_EN
    amostra((^dado) ^ par_inv);
`else
    if (par_inv) begin end
`endif
    amostra(parada);
  endtask

  initial begin
    logic [LARG-1:0] d;
    int              r;

    Reset       = 1'b1;
    Habilita    = 1'b0;
    Dado_serial = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelo_reset();
    checar_saidas("reset_ini");
    Reset = 1'b0;

    // Scenario 1: Habilita every 4 clk
    intervalo = 4;
    ruido     = 1'b0;
    amostra(1'b1);
    enviar_quadro(7'b1100000, 1'b1, 1'b0);
    checar("s1_caractere", 32'(Caractere), 32'h60);
    checar("s1_ocupado", 32'(Ocupado), 32'h0);

    // Scenario 2: back-to-back frames
    enviar_quadro(7'b1000100, 1'b1, 1'b0);
    checar("s2a_caractere", 32'(Caractere), 32'h44);
    enviar_quadro(7'b1110101, 1'b1, 1'b0);
    checar("s2b_caractere", 32'(Caractere), 32'h75);

    // Scenario 3: bad stop, line held low, then recovery
    enviar_quadro(7'b1011010, 1'b0, 1'b0);
    checar("s3_caractere_mantido", 32'(Caractere), 32'h75);
    repeat (5) amostra(1'b0);
    checar("s3_ocupado_baixo", 32'(Ocupado), 32'h0);
    amostra(1'b1);
    enviar_quadro(7'b1101110, 1'b1, 1'b0);
    checar("s3_caractere", 32'(Caractere), 32'h6e);

    // Scenario 4: reset after three data bits
    amostra(1'b0);
    repeat (3) amostra(1'b1);
    aplicar_reset();
    checar("s4_caractere_zero", 32'(Caractere), 32'h0);
    enviar_quadro(7'b1001001, 1'b1, 1'b0);
    checar("s4_caractere", 32'(Caractere), 32'h49);

    // Scenario 5: line toggling between samples
    ruido = 1'b1;
    enviar_quadro(7'b1100000, 1'b1, 1'b0);
    checar("s5_caractere", 32'(Caractere), 32'h60);
    ruido = 1'b0;

`ifdef RECEPTOR_PARIDADE_EN
    // Scenario 6: parity good, then parity bad
    enviar_quadro(7'b1010011, 1'b1, 1'b0);
    checar("s6a_caractere", 32'(Caractere), 32'h53);
    enviar_quadro(7'b1010011, 1'b1, 1'b1);
    checar("s6b_caractere", 32'(Caractere), 32'h53);
`endif

    // Randomized frames, gaps, noise, faults and resets
    for (int n = 0; n < 60; n++) begin
      intervalo = $urandom_range(1, 5);
      ruido     = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) amostra(1'b1);
      r = $urandom_range(0, 15);
      d = LARG'($urandom);
      if (r == 0) begin
        amostra(1'b0);
        repeat ($urandom_range(1, N_CORPO - 1)) amostra(1'($urandom_range(0, 1)));
        aplicar_reset();
      end else begin
        enviar_quadro(d, (r >= 3), (r == 3));
        if (r < 3) begin
          repeat ($urandom_range(0, 3)) amostra(1'b0);
          amostra(1'b1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
    $finish;
  end

endmodule
